io_read_port_fifo: RTL and testbench



---
 rtl/io_read_port_fifo_pkg.sv | 12 +
 rtl/io_read_port_fifo_storage.sv | 39 +++
 rtl/io_read_port_fifo.sv | 98 +++++++++
 tb/tb_io_read_port_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_read_port_fifo_pkg.sv
// Shared defaults for the I/O read-port FIFO and its storage array.
package io_read_port_fifo_pkg;

  localparam int unsigned FIFO_WORD_WIDTH = 36;
  localparam int unsigned FIFO_DEPTH      = 8;
  localparam int unsigned FIFO_ADDR_WIDTH = 3;
  localparam string       FIFO_RAMSTYLE   = "MLAB";

  // Width of the optional underflow/overflow event counters.
  localparam int unsigned STATS_WIDTH     = 16;

endpackage

// File: rtl/io_read_port_fifo_storage.sv
// Simple dual-port array: one synchronous write port, one asynchronous read port.
// Kept generic so the future write-port FIFO can reuse it.
module fifo_storage
  import io_read_port_fifo_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = FIFO_WORD_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter string       RAMSTYLE   = FIFO_RAMSTYLE
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data
);

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH < 2 || DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("fifo_storage: DEPTH must be a power of two >= 2 and equal 2**ADDR_WIDTH");
  end
  if (RAMSTYLE == "") begin : g_bad_ramstyle
    $error("fifo_storage: RAMSTYLE must not be empty");
  end

  (* ramstyle = RAMSTYLE *) logic [WORD_WIDTH-1:0] mem [DEPTH];

  // Write port; contents are intentionally never reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read gives first-word-fall-through at the consumer.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/io_read_port_fifo.sv
// First-word-fall-through FIFO feeding one CPU I/O read port.
// Upstream valid/ready, downstream EF/rden/data.
// Optional event counters enabled by defining IO_READ_PORT_FIFO_STATS_EN.
module io_read_port_fifo
  import io_read_port_fifo_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = FIFO_WORD_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter string       RAMSTYLE   = FIFO_RAMSTYLE
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_WIDTH-1:0]  in_data,
  output logic                   io_in_EF,
  input  logic                   io_rden,
  output logic [WORD_WIDTH-1:0]  io_in,
`ifdef IO_READ_PORT_FIFO_STATS_EN
  output logic [STATS_WIDTH-1:0] underflow_count,
  output logic [STATS_WIDTH-1:0] overflow_count,
`endif
  output logic [ADDR_WIDTH:0]    count
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  push;
  logic                  pop;
  logic [WORD_WIDTH-1:0] head_data;

  // Handshake decode and occupancy update; full/empty come from count only.
  always_comb begin
    push       = in_valid && in_ready;
    pop        = io_rden && !io_in_EF;
    count_next = count + CW'(push) - CW'(pop);
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
      io_in_EF <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      count    <= count_next;
      in_ready <= (count_next < CW'(DEPTH));
      io_in_EF <= (count_next == '0);
    end
  end

  fifo_storage #(
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAMSTYLE   (RAMSTYLE)
  ) u_storage (
    .clock   (clock),
    .we      (push && !reset),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (head_data)
  );

  // Head word is forced to zero while empty so stale storage never leaks out.
  assign io_in = io_in_EF ? '0 : head_data;

`ifdef IO_READ_PORT_FIFO_STATS_EN
  // Saturating counters of rejected pops and rejected pushes.
  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_count <= '0;
      overflow_count  <= '0;
    end else begin
      if (io_rden && io_in_EF && (underflow_count != '1)) begin
        underflow_count <= underflow_count + STATS_WIDTH'(1);
      end
      if (in_valid && !in_ready && (overflow_count != '1)) begin
        overflow_count <= overflow_count + STATS_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_io_read_port_fifo.sv
// Self-checking bench for io_read_port_fifo against a queue-based reference model.
module tb_io_read_port_fifo;

  localparam int unsigned WW    = 36;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_data;
  logic          io_in_EF;
  logic          io_rden;
  logic [WW-1:0] io_in;
  logic [AW:0]   count;
`ifdef IO_READ_PORT_FIFO_STATS_EN
  logic [15:0]   underflow_count;
  logic [15:0]   overflow_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: queue contents, registered ready, and event tallies.
  logic [WW-1:0] q[$];
  bit            m_ready = 1'b0;
  int            m_under = 0;
  int            m_over  = 0;

  io_read_port_fifo #(
    .WORD_WIDTH (WW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .RAMSTYLE   ("MLAB")
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .io_in_EF (io_in_EF),
    .io_rden  (io_rden),
    .io_in    (io_in),
`ifdef IO_READ_PORT_FIFO_STATS_EN
    .underflow_count (underflow_count),
    .overflow_count  (overflow_count),
`endif
    .count    (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [WW-1:0] exp_head();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return #1 later.
  task automatic cycle(input bit r, input bit v, input logic [WW-1:0] d, input bit rd);
    bit do_push;
    bit do_pop;
    reset = r; in_valid = v; in_data = d; io_rden = rd;
    @(posedge clock);
    if (r) begin
      q.delete();
      m_ready = 1'b0;
      m_under = 0;
      m_over  = 0;
    end else begin
      do_push = v && m_ready;
      do_pop  = rd && (q.size() != 0);
      if (rd && q.size() == 0) m_under = (m_under < 65535) ? m_under + 1 : m_under;
      if (v && !m_ready)       m_over  = (m_over  < 65535) ? m_over  + 1 : m_over;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
      m_ready = (q.size() < DEPTH);
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, '0, 0);
    cycle(1, 1, 36'h5, 1);
    checks++; if (io_in_EF !== 1'b1) begin failures++; $display("FAIL reset_ef got=%0b exp=1", io_in_EF); end
    checks++; if (io_in !== '0) begin failures++; $display("FAIL reset_io_in got=%h exp=0", io_in); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", in_ready); end
    cycle(0, 0, '0, 0);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b exp=1", in_ready); end
`ifdef IO_READ_PORT_FIFO_STATS_EN
    checks++; if (underflow_count !== 16'd0 || overflow_count !== 16'd0) begin
      failures++; $display("FAIL reset_stats under=%0d over=%0d exp=0/0", underflow_count, overflow_count);
    end
`endif
  endtask

  task automatic test_first_word();
    checks++; if (io_in_EF !== 1'b1) begin failures++; $display("FAIL first_ef_c0 got=%0b exp=1", io_in_EF); end
    cycle(0, 1, 36'h1, 0);
    checks++; if (io_in_EF !== 1'b0) begin failures++; $display("FAIL first_ef_c1 got=%0b exp=0", io_in_EF); end
    checks++; if (io_in !== 36'h1) begin failures++; $display("FAIL first_io_in got=%h exp=1", io_in); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL first_count got=%0d exp=1", count); end
    cycle(0, 0, '0, 1);
    checks++; if (io_in_EF !== 1'b1 || count !== 4'd0) begin
      failures++; $display("FAIL first_drain ef=%0b count=%0d exp=1/0", io_in_EF, count);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%0b exp=1", i, in_ready); end
      cycle(0, 1, WW'(36'h10 + i), 0);
    end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_full got=%0b exp=0", in_ready); end
    cycle(0, 1, 36'h99, 0);
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL ninth_count got=%0d exp=8", count); end
    checks++; if (io_in !== 36'h10) begin failures++; $display("FAIL ninth_head got=%h exp=10", io_in); end
`ifdef IO_READ_PORT_FIFO_STATS_EN
    checks++; if (overflow_count !== 16'd1) begin failures++; $display("FAIL overflow_count got=%0d exp=1", overflow_count); end
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      checks++; if (io_in !== WW'(36'h10 + i)) begin
        failures++; $display("FAIL drain_order[%0d] got=%h exp=%h", i, io_in, WW'(36'h10 + i));
      end
      cycle(0, 0, '0, 1);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drain_ready[%0d] got=%0b exp=1", i, in_ready); end
    end
    checks++; if (io_in_EF !== 1'b1) begin failures++; $display("FAIL drain_ef got=%0b exp=1", io_in_EF); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] prev;
    logic [WW-1:0] word;
    prev = WW'({$urandom, $urandom});
    cycle(0, 1, prev, 0);
    for (int i = 0; i < 20; i++) begin
      word = WW'({$urandom, $urandom});
      checks++; if (io_in !== prev) begin failures++; $display("FAIL stream_head[%0d] got=%h exp=%h", i, io_in, prev); end
      cycle(0, 1, word, 1);
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, count); end
      prev = word;
    end
    cycle(0, 0, '0, 1);
    checks++; if (io_in_EF !== 1'b1) begin failures++; $display("FAIL stream_end_ef got=%0b exp=1", io_in_EF); end
  endtask

  task automatic test_underflow();
`ifdef IO_READ_PORT_FIFO_STATS_EN
    int base;
    base = int'(underflow_count);
`endif
    for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1);
    checks++; if (count !== 4'd0 || io_in_EF !== 1'b1 || io_in !== '0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL underflow_state count=%0d ef=%0b io_in=%h ready=%0b exp=0/1/0/1", count, io_in_EF, io_in, in_ready);
    end
`ifdef IO_READ_PORT_FIFO_STATS_EN
    checks++; if (int'(underflow_count) - base !== 3) begin
      failures++; $display("FAIL underflow_count delta got=%0d exp=3", int'(underflow_count) - base);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cycle(0, 1, WW'(36'h50 + i), 0);
    checks++; if (count !== 4'd5) begin failures++; $display("FAIL mid_prefill got=%0d exp=5", count); end
    cycle(1, 1, 36'h77, 1);
    checks++; if (count !== 4'd0 || io_in_EF !== 1'b1 || io_in !== '0) begin
      failures++; $display("FAIL mid_reset count=%0d ef=%0b io_in=%h exp=0/1/0", count, io_in_EF, io_in);
    end
    cycle(0, 0, '0, 0);
    cycle(0, 1, 36'hAB, 0);
    checks++; if (io_in !== 36'hAB || count !== 4'd1) begin
      failures++; $display("FAIL mid_first_word io_in=%h count=%0d exp=ab/1", io_in, count);
    end
    cycle(0, 0, '0, 1);
  endtask

  task automatic test_random();
    bit r, v, rd;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 99) < 60);
      rd = ($urandom_range(0, 99) < 50);
      cycle(r, v, WW'({$urandom, $urandom}), rd);
      checks++;
      if (count !== (AW+1)'(q.size()) || io_in_EF !== (q.size() == 0) ||
          io_in !== exp_head() || in_ready !== m_ready) begin
        failures++;
        $display("FAIL random[%0d] count=%0d/%0d ef=%0b/%0b io_in=%h/%h ready=%0b/%0b",
                 i, count, q.size(), io_in_EF, (q.size() == 0), io_in, exp_head(), in_ready, m_ready);
      end
`ifdef IO_READ_PORT_FIFO_STATS_EN
      checks++;
      if (int'(underflow_count) !== m_under || int'(overflow_count) !== m_over) begin
        failures++;
        $display("FAIL random_stats[%0d] under=%0d/%0d over=%0d/%0d", i, underflow_count, m_under, overflow_count, m_over);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; io_rden = 1'b0;
    test_reset();
    test_first_word();
    test_fill();
    test_drain();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
